// File: rtl/ee354_bin2bcd.sv
// Sequential shift-add-3 binary-to-BCD converter with Start/Ack handshake and SCEN single-step.
// Latency: 1 clock in I + WIDTH SCEN-enabled clocks in SHIFT; SCEN=0 stalls SHIFT, DONE holds until Ack.
module ee354_bin2bcd #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  SCEN,
    input  logic                  Start,
    input  logic                  Ack,
    input  logic [WIDTH-1:0]      Bin,
    output logic [4*DIGITS-1:0]   BCD,
    output logic                  q_I,
    output logic                  q_Shift,
    output logic                  q_Done
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    typedef enum logic [2:0] {
        S_I     = 3'b001,
        S_SHIFT = 3'b010,
        S_DONE  = 3'b100
    } state_t;

    state_t                state_q, state_d;
    logic [WIDTH-1:0]      bin_q, bin_d;
    logic [4*DIGITS-1:0]   bcd_q, bcd_d;
    logic [4*DIGITS-1:0]   adj;
    logic [CW-1:0]         cnt_q, cnt_d;

    // Digits >= 5 get +3 before the shift so that doubling carries correctly into the next digit.
    always_comb begin
        adj = bcd_q;
        for (int k = 0; k < DIGITS; k++) begin
            if (bcd_q[4*k +: 4] >= 4'd5) begin
                adj[4*k +: 4] = bcd_q[4*k +: 4] + 4'd3;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        bin_d   = bin_q;
        bcd_d   = bcd_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_I: begin
                bin_d = Bin;
                bcd_d = '0;
                cnt_d = '0;
                if (Start) begin
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (SCEN) begin
                    {bcd_d, bin_d} = {adj, bin_q} << 1;
                    cnt_d          = cnt_q + CW'(1);
                    if (cnt_q == LAST_CNT) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                if (Ack) begin
                    state_d = S_I;
                end
            end
            // Illegal one-hot codes poison the state; only Reset recovers.
            default: state_d = state_t'(3'bxxx);
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= S_I;
            bin_q   <= '0;
            bcd_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            bin_q   <= bin_d;
            bcd_q   <= bcd_d;
            cnt_q   <= cnt_d;
        end
    end

    assign BCD     = bcd_q;
    assign q_I     = state_q[0];
    assign q_Shift = state_q[1];
    assign q_Done  = state_q[2];

endmodule

// File: tb/tb_ee354_bin2bcd.sv
// Scoreboard bench for ee354_bin2bcd: expected BCD queued at Start, popped when q_Done rises.
module tb_ee354_bin2bcd;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        SCEN;
    logic        Start;
    logic        Ack;
    logic [7:0]  Bin;
    logic [11:0] BCD;
    logic        q_I, q_Shift, q_Done;

    int n_checks = 0;
    int n_fail   = 0;
    logic [11:0] exp_q[$];
    logic        done_prev = 1'b0;

    ee354_bin2bcd #(.WIDTH(8), .DIGITS(3)) dut (
        .Clk    (Clk),
        .Reset  (Reset),
        .SCEN   (SCEN),
        .Start  (Start),
        .Ack    (Ack),
        .Bin    (Bin),
        .BCD    (BCD),
        .q_I    (q_I),
        .q_Shift(q_Shift),
        .q_Done (q_Done)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [11:0] ref_bcd(input int v);
        ref_bcd = 12'((((v / 100) % 10) << 8) | (((v / 10) % 10) << 4) | (v % 10));
    endfunction

    function automatic int gcd(input int a, input int b);
        int x = a;
        int y = b;
        int t;
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    // Monitor: one scoreboard pop per rising edge of q_Done.
    initial begin
        forever begin
            @(negedge Clk);
            if (q_Done && !done_prev) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_done", 32'(BCD), 32'hFFFF_FFFF);
                end else begin
                    chk("scoreboard_bcd", 32'(BCD), 32'(exp_q.pop_front()));
                end
            end
            done_prev = q_Done;
        end
    end

    task automatic wait_done();
        int n = 0;
        while (!q_Done && n < 100) begin
            @(negedge Clk);
            n++;
        end
        if (!q_Done) chk("done_timeout", 32'(n), 32'd0);
    endtask

    task automatic ack_done();
        Ack = 1'b1;
        @(negedge Clk);
        Ack = 1'b0;
        chk("ack_to_idle", 32'({q_Done, q_Shift, q_I}), 32'b001);
    endtask

    task automatic convert_run(input logic [7:0] b, input logic [11:0] exp);
        @(negedge Clk);
        Bin   = b;
        Start = 1'b1;
        exp_q.push_back(exp);
        @(negedge Clk);
        Start = 1'b0;
        wait_done();
        ack_done();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [11:0] snap;
        int lat;
        Reset = 1'b1; SCEN = 1'b1; Start = 1'b0; Ack = 1'b0; Bin = 8'd0;
        #1;
        chk("reset_state", 32'({q_Done, q_Shift, q_I}), 32'b001);
        chk("reset_bcd", 32'(BCD), 32'h000);
        @(negedge Clk);
        @(negedge Clk);
        Reset = 1'b0;

        // Reset asserted mid-conversion after 3 shifts.
        @(negedge Clk);
        Bin = 8'd200; Start = 1'b1;
        @(negedge Clk);
        Start = 1'b0;
        @(negedge Clk);
        @(negedge Clk);
        @(negedge Clk);
        chk("midshift_state", 32'({q_Done, q_Shift, q_I}), 32'b010);
        #2 Reset = 1'b1;
        #1;
        chk("async_reset_state", 32'({q_Done, q_Shift, q_I}), 32'b001);
        chk("async_reset_bcd", 32'(BCD), 32'h000);
        @(negedge Clk);
        Reset = 1'b0;
        convert_run(8'd200, 12'h200);

        // Full-range value with latency measurement.
        @(negedge Clk);
        Bin = 8'd255; Start = 1'b1;
        exp_q.push_back(12'h255);
        lat = 0;
        while (!q_Done && lat < 50) begin
            @(negedge Clk);
            lat++;
            Start = 1'b0;
        end
        chk("latency_255", 32'(lat), 32'd9);
        Ack = 1'b1;
        @(negedge Clk);
        Ack = 1'b0;
        chk("ack_state_255", 32'({q_Done, q_Shift, q_I}), 32'b001);
        chk("bcd_held_first_idle", 32'(BCD), 32'h255);
        @(negedge Clk);
        chk("bcd_cleared_in_idle", 32'(BCD), 32'h000);

        convert_run(8'd0, 12'h000);
        convert_run(8'd99, 12'h099);
        convert_run(8'd100, 12'h100);

        // SCEN pulsed once every 4th clock.
        @(negedge Clk);
        Bin = 8'd37; Start = 1'b1;
        exp_q.push_back(12'h037);
        @(negedge Clk);
        Start = 1'b0; SCEN = 1'b0;
        for (int p = 0; p < 8; p++) begin
            repeat (3) begin
                snap = BCD;
                @(negedge Clk);
                chk("stall_state", 32'({q_Done, q_Shift, q_I}), 32'b010);
                chk("stall_bcd", 32'(BCD), 32'(snap));
            end
            SCEN = 1'b1;
            @(negedge Clk);
            SCEN = 1'b0;
        end
        chk("scen_done", 32'(q_Done), 32'd1);
        chk("scen_bcd", 32'(BCD), 32'h037);
        SCEN = 1'b1;
        ack_done();

        // Start held in DONE is ignored; Start+Ack returns to I then SHIFT.
        @(negedge Clk);
        Bin = 8'd123; Start = 1'b1;
        exp_q.push_back(12'h123);
        @(negedge Clk);
        wait_done();
        for (int i = 0; i < 10; i++) begin
            @(negedge Clk);
            chk("done_hold_state", 32'({q_Done, q_Shift, q_I}), 32'b100);
            chk("done_hold_bcd", 32'(BCD), 32'h123);
        end
        Ack = 1'b1;
        exp_q.push_back(12'h123);
        @(negedge Clk);
        chk("start_ack_to_idle", 32'({q_Done, q_Shift, q_I}), 32'b001);
        @(negedge Clk);
        chk("start_ack_wins", 32'({q_Done, q_Shift, q_I}), 32'b010);
        Start = 1'b0; Ack = 1'b0;
        Bin = 8'd7;
        wait_done();
        ack_done();

        // GCD(36,24) result fed through as the chained downstream value.
        convert_run(8'(gcd(36, 24)), 12'h012);

        for (int v = 0; v < 256; v++) begin
            convert_run(8'(v), ref_bcd(v));
        end

        @(negedge Clk);
        @(negedge Clk);
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
